// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding.
package countdown_timer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/count_down_core.sv
// WIDTH-bit down-count register with synchronous load and saturating decrement.
module count_down_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             is_one,
   output logic             is_zero
);

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;

   // Count register: load wins over decrement; decrement never passes zero.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - CNT_ONE;
      end
   end

   assign count   = count_q;
   assign is_one  = (count_q == CNT_ONE);
   assign is_zero = (count_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing, one-shot or auto-reload.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | count holds; waits for start
// RUN   | decrements once per tick; tc on expiry, reload or go to DONE
// DONE  | count is 0, done level held until ack
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int               WIDTH      = 4,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             pre,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start,
   input  logic             tick,
   input  logic             reload_mode,
   input  logic             ack,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             tc,
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;

   logic             core_load;
   logic             core_dec;
   logic [WIDTH-1:0] core_load_val;
   logic [WIDTH-1:0] count;
   logic             is_one;
   logic             is_zero;

   count_down_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .clear_n  (clear_n),
      .load     (core_load),
      .dec      (core_dec),
      .load_val (core_load_val),
      .count    (count),
      .is_one   (is_one),
      .is_zero  (is_zero)
   );

   // State, reload value and tc pulse registers.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state_q  <= S_IDLE;
         reload_q <= '0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
      end
   end

   // Next-state and counter control; pre/en abort whatever is in progress.
   always_comb begin
      state_d       = state_q;
      reload_d      = reload_q;
      tc_d          = 1'b0;
      core_load     = 1'b0;
      core_dec      = 1'b0;
      core_load_val = count;

      if (pre) begin
         core_load     = 1'b1;
         core_load_val = PRESET_VAL;
         reload_d      = PRESET_VAL;
         state_d       = S_IDLE;
      end else if (en) begin
         core_load     = 1'b1;
         core_load_val = data_in;
         reload_d      = data_in;
         state_d       = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (is_zero) begin
                     // Zero-length interval expires immediately.
                     tc_d    = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (tick) begin
                  if (is_one) begin
                     tc_d      = 1'b1;
                     core_load = 1'b1;
                     if (reload_mode && (reload_q != '0)) begin
                        core_load_val = reload_q;
                     end else begin
                        core_load_val = '0;
                        state_d       = S_DONE;
                     end
                  end else begin
                     core_dec = 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (ack) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign data_out = count;
   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign tc       = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: reset, one-shot, auto-reload, gated tick, preset, edge cases.
module tb_countdown_timer;

   logic       clk;
   logic       clear_n;
   logic       pre;
   logic       en;
   logic [3:0] data_in;
   logic       start;
   logic       tick;
   logic       reload_mode;
   logic       ack;
   logic [3:0] data_out;
   logic       busy;
   logic       tc;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   countdown_timer #(
      .WIDTH      (4),
      .PRESET_VAL (4'hF)
   ) dut (
      .clk         (clk),
      .clear_n     (clear_n),
      .pre         (pre),
      .en          (en),
      .data_in     (data_in),
      .start       (start),
      .tick        (tick),
      .reload_mode (reload_mode),
      .ack         (ack),
      .data_out    (data_out),
      .busy        (busy),
      .tc          (tc),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_val);
      n_checks++;
      if (obs !== exp_val) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int e_cnt, input int e_busy,
                          input int e_tc, input int e_done);
      chk({tag, ".data_out"}, int'(data_out), e_cnt);
      chk({tag, ".busy"},     int'(busy),     e_busy);
      chk({tag, ".tc"},       int'(tc),       e_tc);
      chk({tag, ".done"},     int'(done),     e_done);
   endtask

   initial begin
      int cnt;
      int exp_tc;
      int tc_seen;

      clear_n = 1'b0; pre = 1'b0; en = 1'b1; data_in = 4'd5;
      start = 1'b0; tick = 1'b0; reload_mode = 1'b0; ack = 1'b0;

      // 1 reset dominates load
      step();
      step();
      chk_all("reset", 0, 0, 0, 0);
      clear_n = 1'b1; en = 1'b0;
      step();
      chk_all("reset_hold", 0, 0, 0, 0);

      // 2 one-shot interval 5
      en = 1'b1; data_in = 4'd5;
      step();
      chk_all("os_load", 5, 0, 0, 0);
      en = 1'b0; start = 1'b1; tick = 1'b1;
      step();
      chk_all("os_start", 5, 1, 0, 0);
      start = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         step();
         chk_all("os_count", i, 1, 0, 0);
      end
      step();
      chk_all("os_expire", 0, 0, 1, 1);
      step();
      chk_all("os_done_hold", 0, 0, 0, 1);
      ack = 1'b1;
      step();
      chk_all("os_ack", 0, 0, 0, 0);
      ack = 1'b0; tick = 1'b0;

      // 3 auto-reload interval 3
      en = 1'b1; data_in = 4'd3; reload_mode = 1'b1;
      step();
      chk_all("ar_load", 3, 0, 0, 0);
      en = 1'b0; start = 1'b1; tick = 1'b1;
      step();
      chk_all("ar_start", 3, 1, 0, 0);
      start = 1'b0;
      tc_seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         cnt    = (k % 3 == 0) ? 2 : ((k % 3 == 1) ? 1 : 3);
         exp_tc = (k % 3 == 2) ? 1 : 0;
         chk_all("ar_period", cnt, 1, exp_tc, 0);
         tc_seen += int'(tc);
      end
      chk("ar_tc_count", tc_seen, 2);
      reload_mode = 1'b0;
      step();
      chk_all("ar_last2", 2, 1, 0, 0);
      step();
      chk_all("ar_last1", 1, 1, 0, 0);
      step();
      chk_all("ar_final", 0, 0, 1, 1);
      ack = 1'b1; tick = 1'b0;
      step();
      chk_all("ar_ack", 0, 0, 0, 0);
      ack = 1'b0;

      // 4 gated tick: one tick every third cycle
      en = 1'b1; data_in = 4'd4;
      step();
      en = 1'b0; start = 1'b1;
      step();
      chk_all("gt_start", 4, 1, 0, 0);
      start = 1'b0;
      cnt = 4;
      for (int k = 0; k < 12; k++) begin
         tick = (k % 3 == 2);
         step();
         exp_tc = (tick && cnt == 1) ? 1 : 0;
         if (tick) cnt--;
         chk({"gt_cnt_", $sformatf("%0d", k)}, int'(data_out), cnt);
         chk({"gt_tc_", $sformatf("%0d", k)}, int'(tc), exp_tc);
      end
      tick = 1'b0;
      chk("gt_done", int'(done), 1);
      chk("gt_busy", int'(busy), 0);
      ack = 1'b1;
      step();
      ack = 1'b0;

      // 5 preset aborts a run
      en = 1'b1; data_in = 4'd6;
      step();
      en = 1'b0; start = 1'b1; tick = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk_all("pr_before", 4, 1, 0, 0);
      pre = 1'b1;
      step();
      chk_all("pr_abort", 15, 0, 0, 0);
      pre = 1'b0; start = 1'b1;
      step();
      chk_all("pr_restart", 15, 1, 0, 0);
      start = 1'b0;
      step();
      chk_all("pr_count", 14, 1, 0, 0);
      tick = 1'b0; en = 1'b1; data_in = 4'd0;
      step();
      chk_all("pr_zero_load", 0, 0, 0, 0);
      en = 1'b0;

      // 6a start with count 0 expires immediately
      start = 1'b1;
      step();
      chk_all("ez_start0", 0, 0, 1, 1);
      start = 1'b0;
      step();
      chk_all("ez_done_hold", 0, 0, 0, 1);
      start = 1'b1; ack = 1'b1;
      step();
      chk_all("ez_ack_start", 0, 0, 0, 0);
      start = 1'b0; ack = 1'b0;

      // 6b en while done drops done and loads
      start = 1'b1;
      step();
      start = 1'b0; en = 1'b1; data_in = 4'd7;
      step();
      chk_all("ez_en_done", 7, 0, 0, 0);
      en = 1'b0; tick = 1'b1;
      step();
      chk_all("ez_idle_tick", 7, 0, 0, 0);
      tick = 1'b0;

      // 6c reset mid-run at count 2, about to expire
      en = 1'b1; data_in = 4'd3;
      step();
      en = 1'b0; start = 1'b1; tick = 1'b1;
      step();
      start = 1'b0;
      step();
      chk_all("ez_pre_clr", 2, 1, 0, 0);
      clear_n = 1'b0;
      step();
      chk_all("ez_clear", 0, 0, 0, 0);
      clear_n = 1'b1;
      step();
      chk_all("ez_after_clear", 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
